// File: rtl/seq_alu_pkg.sv
// rtl/seq_alu_pkg.sv - op codes, FSM states and flag bit positions for seq_alu
package seq_alu_pkg;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_SLT = 3'b101;
  localparam logic [2:0] OP_MUL = 3'b110;
  localparam logic [2:0] OP_ILL = 3'b111;

  // flags = {err, V, N, Z, C}
  localparam int FLAG_C   = 0;
  localparam int FLAG_Z   = 1;
  localparam int FLAG_N   = 2;
  localparam int FLAG_V   = 3;
  localparam int FLAG_ERR = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/seq_alu_mul.sv
// rtl/seq_alu_mul.sv - shift-add unsigned multiplier, one multiplier bit per cycle
module seq_alu_mul #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  localparam int CW = $clog2(WIDTH + 1);

  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [2*WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0]   mplier_q, mplier_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               busy_q, busy_d;
  logic [2*WIDTH-1:0] step_sum;

  // Partial-product accumulation; done flags the final step so the caller
  // can capture the full product on the same edge it is formed.
  always_comb begin
    step_sum = acc_q + (mplier_q[0] ? mcand_q : '0);
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    cnt_d    = cnt_q;
    busy_d   = busy_q;
    if (start) begin
      acc_d    = '0;
      mcand_d  = {{WIDTH{1'b0}}, a};
      mplier_d = b;
      cnt_d    = CW'(WIDTH);
      busy_d   = 1'b1;
    end else if (busy_q) begin
      acc_d    = step_sum;
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
      cnt_d    = cnt_q - CW'(1);
      if (cnt_q == CW'(1)) begin
        busy_d = 1'b0;
      end
    end
    done    = busy_q && (cnt_q == CW'(1));
    product = step_sum;
  end

  // Multiplier state registers; reset abandons any operation in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
    end else begin
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      cnt_q    <= cnt_d;
      busy_q   <= busy_d;
    end
  end

endmodule

// File: rtl/seq_alu.sv
// rtl/seq_alu.sv - sequential ALU with valid/ready handshake; SEQ_ALU_MUL_EN enables MUL
module seq_alu
  import seq_alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] result_hi,
  output logic [4:0]       flags
);

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   result_q, result_d;
  logic [WIDTH-1:0]   result_hi_q, result_hi_d;
  logic [4:0]         flags_q, flags_d;

  logic [WIDTH:0]     sum_ext;
  logic [WIDTH-1:0]   alu_res;
  logic [4:0]         alu_flags;
  logic               is_mul;
  logic               mul_done;
  logic [2*WIDTH-1:0] mul_product;
  logic [4:0]         mul_flags;

`ifdef SEQ_ALU_MUL_EN
  logic mul_start;

  assign is_mul = (op == OP_MUL);

  seq_alu_mul #(
    .WIDTH(WIDTH)
  ) u_mul (
    .clk     (clk),
    .rst     (rst),
    .start   (mul_start),
    .a       (a),
    .b       (b),
    .done    (mul_done),
    .product (mul_product)
  );
`else
  // Without the multiplier, MUL decodes as illegal in the ALU below.
  assign is_mul      = 1'b0;
  assign mul_done    = 1'b0;
  assign mul_product = '0;
`endif

  // Single-cycle ops evaluated straight from the request inputs at accept time.
  always_comb begin
    sum_ext   = '0;
    alu_res   = '0;
    alu_flags = '0;
    case (op)
      OP_ADD: begin
        sum_ext            = {1'b0, a} + {1'b0, b};
        alu_res            = sum_ext[WIDTH-1:0];
        alu_flags[FLAG_C]  = sum_ext[WIDTH];
        alu_flags[FLAG_V]  = (a[WIDTH-1] == b[WIDTH-1]) && (alu_res[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SUB: begin
        sum_ext            = {1'b0, a} + {1'b0, ~b} + {{WIDTH{1'b0}}, 1'b1};
        alu_res            = sum_ext[WIDTH-1:0];
        alu_flags[FLAG_C]  = sum_ext[WIDTH];
        alu_flags[FLAG_V]  = (a[WIDTH-1] != b[WIDTH-1]) && (alu_res[WIDTH-1] != a[WIDTH-1]);
      end
      OP_AND: alu_res = a & b;
      OP_OR:  alu_res = a | b;
      OP_XOR: alu_res = a ^ b;
      OP_SLT: alu_res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      default: alu_flags[FLAG_ERR] = 1'b1;
    endcase
    if (!alu_flags[FLAG_ERR]) begin
      alu_flags[FLAG_Z] = (alu_res == '0);
      alu_flags[FLAG_N] = alu_res[WIDTH-1];
    end
  end

  // MUL flags look at the whole double-width product.
  always_comb begin
    mul_flags         = '0;
    mul_flags[FLAG_Z] = (mul_product == '0);
    mul_flags[FLAG_N] = mul_product[2*WIDTH-1];
  end

  // Handshake FSM: retire in DONE and accept a new request on the same edge.
  always_comb begin
    state_d     = state_q;
    result_d    = result_q;
    result_hi_d = result_hi_q;
    flags_d     = flags_q;
    in_ready    = 1'b0;
    out_valid   = 1'b0;
`ifdef SEQ_ALU_MUL_EN
    mul_start   = 1'b0;
`endif
    case (state_q)
      ST_IDLE: begin
        in_ready = 1'b1;
      end
      ST_BUSY: begin
        if (mul_done) begin
          state_d     = ST_DONE;
          result_d    = mul_product[WIDTH-1:0];
          result_hi_d = mul_product[2*WIDTH-1:WIDTH];
          flags_d     = mul_flags;
        end
      end
      ST_DONE: begin
        out_valid = 1'b1;
        in_ready  = out_ready;
        if (out_ready && !in_valid) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (in_valid && in_ready) begin
      if (is_mul) begin
        state_d   = ST_BUSY;
`ifdef SEQ_ALU_MUL_EN
        mul_start = 1'b1;
`endif
      end else begin
        state_d     = ST_DONE;
        result_d    = alu_res;
        result_hi_d = '0;
        flags_d     = alu_flags;
      end
    end
  end

  // State and result registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      result_q    <= '0;
      result_hi_q <= '0;
      flags_q     <= '0;
    end else begin
      state_q     <= state_d;
      result_q    <= result_d;
      result_hi_q <= result_hi_d;
      flags_q     <= flags_d;
    end
  end

  assign result    = result_q;
  assign result_hi = result_hi_q;
  assign flags     = flags_q;

endmodule
